// File: rtl/multiply_add.sv
// Sequential shift-and-add multiply-accumulate: result = factor_a*factor_b + addend.
// One multiplier bit per cycle over WIDTH cycles, with a registered done pulse and overflow flag.
module multiply_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] factor_a,
    input  logic [WIDTH-1:0] factor_b,
    input  logic [WIDTH-1:0] addend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_accept;
    logic               w_last;

    // Next-state logic; start is only accepted outside RUN
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_cnt == CNT_W'(WIDTH - 1));
        w_acc_sum    = r_acc;
        if (r_b[r_cnt]) begin
            w_acc_sum = r_acc + (ACC_W'(r_a) << r_cnt);
        end
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            busy    <= (w_state_next == S_RUN);
            done    <= (w_state_next == S_FINISH);
            if (w_accept) begin
                r_a   <= factor_a;
                r_b   <= factor_b;
                r_acc <= ACC_W'(addend);
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_sum;
                r_cnt <= r_cnt + CNT_W'(1);
                // Outputs only move on the edge that completes the operation
                if (w_last) begin
                    result   <= w_acc_sum[WIDTH-1:0];
                    overflow <= |w_acc_sum[ACC_W-1:WIDTH];
                end
            end
        end
    end

endmodule
